// File: rtl/avgai_pkg.sv
// Shared constants and types for the framebuffer display path.
package avgai_pkg;

    localparam int DEF_PIX_W   = 12;
    localparam int DEF_COORD_W = 8;
    localparam int DEF_SCR_W   = 10;

    // Scale shift applied after reset (4x).
    localparam logic [1:0] SCALE_RESET = 2'd2;

    // Host write entry as held in the write FIFO, most significant field first.
    typedef struct packed {
        logic [DEF_COORD_W-1:0] x;
        logic [DEF_COORD_W-1:0] y;
        logic [DEF_PIX_W-1:0]   data;
    } wr_entry_t;

    localparam int WR_ENTRY_W = $bits(wr_entry_t);

endpackage

// File: rtl/fb_wr_fifo.sv
// Synchronous FIFO with full/empty/level; head entry is visible combinationally.
module fb_wr_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 28
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] store_reg [DEPTH];
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic             do_push;
    logic             do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign level     = wr_ptr_reg - rd_ptr_reg;
    assign full      = (level == (AW + 1)'(DEPTH));
    assign empty     = (level == '0);
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign head_data = store_reg[rd_ptr_reg[AW-1:0]];

    // Entry storage, written on accepted pushes only.
    always_ff @(posedge clk) begin
        if (do_push) begin
            store_reg[wr_ptr_reg[AW-1:0]] <= push_data;
        end
    end

    // Read/write pointer update; reset discards every stored entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + (AW + 1)'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + (AW + 1)'(1);
            end
        end
    end

endmodule

// File: rtl/fb_port_arbiter.sv
// Framebuffer port arbiter: display reads own the memory port, host writes
// queue in a FIFO and drain on cycles the display does not need the port.
module fb_port_arbiter
    import avgai_pkg::*;
#(
    parameter int PIX_W      = DEF_PIX_W,
    parameter int COORD_W    = DEF_COORD_W,
    parameter int SCR_W      = DEF_SCR_W,
    parameter int FIFO_DEPTH = 8,
    parameter int RD_LAT     = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        frame_start,
    input  logic [1:0]                  scale_sel,
    input  logic                        disp_need,
    input  logic [SCR_W-1:0]            disp_h,
    input  logic [SCR_W-1:0]            disp_v,
    input  logic                        wr_valid,
    output logic                        wr_ready,
    input  logic [COORD_W-1:0]          wr_x,
    input  logic [COORD_W-1:0]          wr_y,
    input  logic [PIX_W-1:0]            wr_data,
    output logic                        mem_re,
    output logic                        mem_we,
    output logic [COORD_W-1:0]          mem_x,
    output logic [COORD_W-1:0]          mem_y,
    output logic [PIX_W-1:0]            mem_wdata,
    input  logic [PIX_W-1:0]            mem_rdata,
    output logic [PIX_W-1:0]            pix_out,
    output logic                        pix_valid,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
    localparam int ENTRY_W = 2 * COORD_W + PIX_W;

    logic [1:0]         scale_reg;
    logic [SCR_W-1:0]   sx;
    logic [SCR_W-1:0]   sy;
    logic               in_range;
    logic               rd_go;
    logic               fifo_pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [ENTRY_W-1:0] head_entry;
    logic [RD_LAT-1:0]  need_pipe_reg;
    logic [RD_LAT-1:0]  blank_pipe_reg;

    // Scale only changes at frame boundaries so a frame is never drawn mixed.
    always_ff @(posedge clk) begin
        if (reset) begin
            scale_reg <= SCALE_RESET;
        end else if (frame_start) begin
            scale_reg <= scale_sel;
        end
    end

    // Any coordinate bit left above the memory address width means off-image.
    assign sx       = disp_h >> scale_reg;
    assign sy       = disp_v >> scale_reg;
    assign in_range = ((sx >> COORD_W) == '0) && ((sy >> COORD_W) == '0);
    assign rd_go    = disp_need && in_range && !reset;
    assign fifo_pop = !rd_go && !fifo_empty && !reset;
    assign wr_ready = !fifo_full && !reset;

    fb_wr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_wr_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (wr_valid && wr_ready),
        .push_data ({wr_x, wr_y, wr_data}),
        .pop       (fifo_pop),
        .head_data (head_entry),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    // Port arbitration: an in-range display read wins, else drain one write.
    always_comb begin
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        mem_x     = '0;
        mem_y     = '0;
        mem_wdata = '0;
        if (rd_go) begin
            mem_re = 1'b1;
            mem_x  = COORD_W'(sx);
            mem_y  = COORD_W'(sy);
        end else if (fifo_pop) begin
            mem_we    = 1'b1;
            mem_x     = head_entry[ENTRY_W-1 -: COORD_W];
            mem_y     = head_entry[PIX_W +: COORD_W];
            mem_wdata = head_entry[PIX_W-1:0];
        end
    end

    // Carry (need, blank) alongside the memory read so it lines up with rdata.
    always_ff @(posedge clk) begin
        if (reset) begin
            need_pipe_reg  <= '0;
            blank_pipe_reg <= '0;
        end else begin
            need_pipe_reg[0]  <= disp_need;
            blank_pipe_reg[0] <= disp_need && !in_range;
            for (int i = 1; i < RD_LAT; i++) begin
                need_pipe_reg[i]  <= need_pipe_reg[i-1];
                blank_pipe_reg[i] <= blank_pipe_reg[i-1];
            end
        end
    end

    assign pix_valid = need_pipe_reg[RD_LAT-1] && !reset;
    assign pix_out   = (pix_valid && !blank_pipe_reg[RD_LAT-1]) ? mem_rdata : '0;

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Scoreboard bench for fb_port_arbiter: stimulus pushes expected memory
// accesses and pixels; a negedge monitor pops and compares them.
module tb_fb_port_arbiter;
    localparam int PIX_W   = 12;
    localparam int COORD_W = 8;
    localparam int SCR_W   = 10;
    localparam int DEPTH   = 8;
    localparam int RD_LAT  = 1;

    typedef struct {
        logic               we;
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [PIX_W-1:0]   data;
        int                 cyc;
    } mem_exp_t;

    typedef struct {
        logic [PIX_W-1:0] data;
        int               cyc;
    } pix_exp_t;

    logic clk = 1'b0;
    logic reset, frame_start, disp_need, wr_valid;
    logic [1:0] scale_sel;
    logic [SCR_W-1:0] disp_h, disp_v;
    logic [COORD_W-1:0] wr_x, wr_y, mem_x, mem_y;
    logic [PIX_W-1:0] wr_data, mem_wdata, mem_rdata, pix_out;
    logic wr_ready, mem_re, mem_we, pix_valid;
    logic [$clog2(DEPTH):0] fifo_level;

    mem_exp_t exp_mem[$];
    pix_exp_t exp_pix[$];
    int cyc = 0;
    int checks = 0;
    int failures = 0;
    logic [PIX_W-1:0] rd_pipe [RD_LAT];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fb_port_arbiter #(
        .PIX_W(PIX_W), .COORD_W(COORD_W), .SCR_W(SCR_W),
        .FIFO_DEPTH(DEPTH), .RD_LAT(RD_LAT)
    ) dut (
        .clk(clk), .reset(reset), .frame_start(frame_start), .scale_sel(scale_sel),
        .disp_need(disp_need), .disp_h(disp_h), .disp_v(disp_v),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_x(wr_x), .wr_y(wr_y),
        .wr_data(wr_data), .mem_re(mem_re), .mem_we(mem_we), .mem_x(mem_x),
        .mem_y(mem_y), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .pix_out(pix_out), .pix_valid(pix_valid), .fifo_level(fifo_level)
    );

    // Memory contents as a fixed function of the address.
    function automatic logic [PIX_W-1:0] pix_of(input logic [COORD_W-1:0] x, input logic [COORD_W-1:0] y);
        return {x[5:0], y[5:0]} ^ 12'hA5A;
    endfunction

    // Read-latency memory model; returns garbage when no read was issued.
    always @(posedge clk) begin
        rd_pipe[0] <= mem_re ? pix_of(mem_x, mem_y) : 12'hFFF;
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_rdata = rd_pipe[RD_LAT-1];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s cyc=%0d got=0x%0h want=0x%0h", name, cyc, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        disp_need = 1'b0;
        disp_h = '0;
        disp_v = '0;
    endtask

    // Issue one display request with hand-computed memory address.
    task automatic issue_disp(input int h, input int v, input int ex, input int ey, input bit in_rng);
        mem_exp_t m;
        pix_exp_t p;
        disp_need = 1'b1;
        disp_h = SCR_W'(h);
        disp_v = SCR_W'(v);
        if (in_rng) begin
            m.we = 1'b0; m.x = COORD_W'(ex); m.y = COORD_W'(ey); m.data = '0; m.cyc = cyc;
            exp_mem.push_back(m);
        end
        p.data = in_rng ? pix_of(COORD_W'(ex), COORD_W'(ey)) : '0;
        p.cyc = cyc + RD_LAT;
        exp_pix.push_back(p);
    endtask

    task automatic expect_write(input int x, input int y, input int d, input int at);
        mem_exp_t m;
        m.we = 1'b1; m.x = COORD_W'(x); m.y = COORD_W'(y); m.data = PIX_W'(d); m.cyc = at;
        exp_mem.push_back(m);
    endtask

    // Monitor: every memory strobe and every valid pixel must match the queue head.
    always @(negedge clk) begin
        mem_exp_t m;
        pix_exp_t p;
        if (mem_re || mem_we) begin
            checks++;
            if (exp_mem.size() == 0) begin
                failures++;
                $display("FAIL mem_unexpected cyc=%0d re=%0b we=%0b x=%0d y=%0d", cyc, mem_re, mem_we, mem_x, mem_y);
            end else begin
                m = exp_mem.pop_front();
                if (mem_we !== m.we || mem_re !== !m.we || mem_x !== m.x || mem_y !== m.y
                    || (m.we && mem_wdata !== m.data) || cyc != m.cyc) begin
                    failures++;
                    $display("FAIL mem_access cyc=%0d got re=%0b we=%0b x=%0d y=%0d wd=0x%0h want we=%0b x=%0d y=%0d wd=0x%0h cyc=%0d",
                             cyc, mem_re, mem_we, mem_x, mem_y, mem_wdata, m.we, m.x, m.y, m.data, m.cyc);
                end
            end
        end
        if (pix_valid) begin
            checks++;
            if (exp_pix.size() == 0) begin
                failures++;
                $display("FAIL pix_unexpected cyc=%0d pix_out=0x%0h", cyc, pix_out);
            end else begin
                p = exp_pix.pop_front();
                if (pix_out !== p.data || cyc != p.cyc) begin
                    failures++;
                    $display("FAIL pix cyc=%0d got=0x%0h want=0x%0h at cyc=%0d", cyc, pix_out, p.data, p.cyc);
                end
            end
        end else begin
            check("pix_idle_zero", 32'(pix_out), 32'd0);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; frame_start = 1'b0; scale_sel = 2'd0; wr_valid = 1'b0;
        wr_x = '0; wr_y = '0; wr_data = '0;
        idle();
        repeat (3) step();
        @(negedge clk);
        check("rst_wr_ready", 32'(wr_ready), 32'd0);
        check("rst_mem_re", 32'(mem_re), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        step();
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_wr_ready", 32'(wr_ready), 32'd1);
        check("post_rst_level", 32'(fifo_level), 32'd0);
        check("post_rst_pix_valid", 32'(pix_valid), 32'd0);
        check("post_rst_mem_x", 32'(mem_x), 32'd0);

        // Display read at default scale 2: (40,8) -> (10,2)
        step(); issue_disp(40, 8, 10, 2, 1);
        step(); idle();
        step();

        // Single write with display idle
        step();
        wr_valid = 1'b1; wr_x = 8'd3; wr_y = 8'd4; wr_data = 12'hABC;
        expect_write(3, 4, 12'hABC, cyc + 1);
        @(negedge clk); check("wr_ready_idle", 32'(wr_ready), 32'd1);
        step(); wr_valid = 1'b0;
        @(negedge clk); check("wr_level_one", 32'(fifo_level), 32'd1);
        step();
        @(negedge clk); check("wr_level_zero", 32'(fifo_level), 32'd0);

        // Starve writes under continuous display reads; FIFO fills to 8
        step();
        for (int k = 0; k < 10; k++) begin
            int idx;
            idx = (k < 8) ? k : 8;
            issue_disp(k * 4, 4, k, 1, 1);
            wr_valid = 1'b1; wr_x = COORD_W'(20 + idx); wr_y = 8'd5; wr_data = PIX_W'(12'h100 + idx);
            @(negedge clk);
            check("fill_ready", 32'(wr_ready), (k < 8) ? 32'd1 : 32'd0);
            check("fill_level", 32'(fifo_level), 32'(idx));
            step();
        end
        // Release: 8 queued writes drain back to back, the held 9th follows
        idle();
        for (int j = 0; j < 9; j++) expect_write(20 + j, 5, 12'h100 + j, cyc + j);
        @(negedge clk);
        check("release_ready_full", 32'(wr_ready), 32'd0);
        check("release_level", 32'(fifo_level), 32'd8);
        step();
        @(negedge clk);
        check("release_ready_again", 32'(wr_ready), 32'd1);
        check("release_level_7", 32'(fifo_level), 32'd7);
        step(); wr_valid = 1'b0;
        repeat (8) step();
        @(negedge clk); check("drain_level_zero", 32'(fifo_level), 32'd0);

        // Scale 0 via frame_start; out-of-range blanking; scale timing
        step(); frame_start = 1'b1; scale_sel = 2'd0;
        step(); frame_start = 1'b0; scale_sel = 2'd3; issue_disp(300, 10, 0, 0, 0);
        step(); issue_disp(200, 100, 200, 100, 1);
        step(); frame_start = 1'b1; scale_sel = 2'd1; issue_disp(100, 50, 100, 50, 1);
        step(); frame_start = 1'b0; issue_disp(100, 50, 50, 25, 1);
        step(); issue_disp(10, 600, 0, 0, 0);
        step(); idle();
        step(); step();

        // Fill FIFO to 5 under display reads (scale 1: (8,12)->(4,6)), then reset
        for (int k = 0; k < 5; k++) begin
            issue_disp(8, 12, 4, 6, 1);
            wr_valid = 1'b1; wr_x = COORD_W'(k); wr_y = 8'd0; wr_data = PIX_W'(k);
            @(negedge clk); check("pre_rst_level", 32'(fifo_level), 32'(k));
            step();
        end
        wr_valid = 1'b0;
        issue_disp(8, 12, 4, 6, 1);
        @(negedge clk); check("pre_rst_level5", 32'(fifo_level), 32'd5);
        step();
        reset = 1'b1; idle();
        exp_pix.delete();
        @(negedge clk);
        check("rst_cycle_mem_we", 32'(mem_we), 32'd0);
        check("rst_cycle_wr_ready", 32'(wr_ready), 32'd0);
        step(); reset = 1'b0;
        @(negedge clk);
        check("midrst_level", 32'(fifo_level), 32'd0);
        check("midrst_mem_we", 32'(mem_we), 32'd0);
        check("midrst_pix_valid", 32'(pix_valid), 32'd0);
        // Scale is back to 2 after reset
        step(); issue_disp(40, 8, 10, 2, 1);
        step(); idle();
        step();

        // Full 640-pixel line at scale 2
        for (int h = 0; h < 640; h++) begin
            issue_disp(h, 20, h / 4, 5, 1);
            step();
        end
        idle();
        repeat (RD_LAT + 2) step();
        check("exp_mem_drained", 32'(exp_mem.size()), 32'd0);
        check("exp_pix_drained", 32'(exp_pix.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
